// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//   Hazard control for the RV32IM 5-stage core, sitting beside ID. It tracks
//   registers with an outstanding MUL/DIV writeback, stalls on RAW/WAW against
//   them, stalls a MUL/DIV behind a busy unit, stretches load-use stalls to
//   LOAD_LAT cycles, and counts stall cycles (saturating).
// Ports:
//   clk, rst                     clock, async active-high reset
//   id_*                         operand/dest info of the instruction in ID
//   ex_*                         dest/load/MUL-DIV issue info of EX; ex_redirect
//   md_done, md_rd_addr          MUL/DIV writeback
//   pc_write_en, if_id_enable,
//   if_id_flush, id_ex_flush     front-end pipeline controls
//   md_busy, sb_pending          MUL/DIV occupancy and per-register pending bits
//   stall_count                  saturating stall-cycle counter
module hazard_scoreboard_unit #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_AW-1:0]   id_rs1_addr,
  input  logic [REG_AW-1:0]   id_rs2_addr,
  input  logic                id_rs1_used,
  input  logic                id_rs2_used,
  input  logic [REG_AW-1:0]   id_rd_addr,
  input  logic                id_reg_write_en,
  input  logic                id_is_md,
  input  logic [REG_AW-1:0]   ex_rd_addr,
  input  logic                ex_mem_read_en,
  input  logic                ex_reg_write_en,
  input  logic                ex_md_start,
  input  logic                md_done,
  input  logic [REG_AW-1:0]   md_rd_addr,
  input  logic                ex_redirect,
  output logic                pc_write_en,
  output logic                if_id_enable,
  output logic                if_id_flush,
  output logic                id_ex_flush,
  output logic                md_busy,
  output logic [NUM_REGS-1:0] sb_pending,
  output logic [CNT_W-1:0]    stall_count
);

  localparam int  LD_CW    = 3;
  localparam bit  MULTI_LD = (LOAD_LAT > 1);
  localparam logic [LD_CW-1:0] LD_INIT = LD_CW'(LOAD_LAT - 1);

  typedef enum logic {IDLE, LD_STALL} ld_state_e;

  ld_state_e            ld_state_q, ld_state_d;
  logic [LD_CW-1:0]     ld_cnt_q, ld_cnt_d;
  logic [NUM_REGS-1:0]  sb_q, sb_d;
  logic                 md_busy_q, md_busy_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

  logic sb_hazard, struct_hazard, load_use, stall;

  // Hazards look only at registered scoreboard state: a register completing
  // this cycle still stalls and is released on the following cycle.
  always_comb begin
    sb_hazard = (id_rs1_used     && id_rs1_addr != '0 && sb_q[id_rs1_addr]) ||
                (id_rs2_used     && id_rs2_addr != '0 && sb_q[id_rs2_addr]) ||
                (id_reg_write_en && id_rd_addr  != '0 && sb_q[id_rd_addr]);
    struct_hazard = id_is_md && md_busy_q;
    load_use = ex_mem_read_en && ex_reg_write_en && ex_rd_addr != '0 &&
               ((id_rs1_used && ex_rd_addr == id_rs1_addr) ||
                (id_rs2_used && ex_rd_addr == id_rs2_addr));
    stall = load_use || (ld_state_q == LD_STALL) || sb_hazard || struct_hazard;
  end

  // Scoreboard / busy next state. Issue from EX is never gated: on a redirect
  // the MUL/DIV in EX is older than the redirecting branch and must complete.
  always_comb begin
    sb_d = sb_q;
    if (md_done) sb_d[md_rd_addr] = 1'b0;
    if (ex_md_start && ex_reg_write_en && ex_rd_addr != '0)
      sb_d[ex_rd_addr] = 1'b1;            // set after clear: set wins
    sb_d[0] = 1'b0;

    md_busy_d = md_busy_q;
    if (md_done)     md_busy_d = 1'b0;
    if (ex_md_start) md_busy_d = 1'b1;
  end

  // Load FSM: the first load-use cycle is stalled from IDLE; LD_STALL then
  // covers the remaining LOAD_LAT-1 cycles.
  always_comb begin
    ld_state_d = ld_state_q;
    ld_cnt_d   = ld_cnt_q;
    if (ex_redirect) begin
      ld_state_d = IDLE;
    end else begin
      case (ld_state_q)
        IDLE: if (load_use && MULTI_LD) begin
          ld_state_d = LD_STALL;
          ld_cnt_d   = LD_INIT;
        end
        LD_STALL: begin
          if (ld_cnt_q <= LD_CW'(1)) ld_state_d = IDLE;
          else                       ld_cnt_d   = ld_cnt_q - LD_CW'(1);
        end
        default: ld_state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !ex_redirect && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q        <= '0;
      md_busy_q   <= 1'b0;
      ld_state_q  <= IDLE;
      ld_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      md_busy_q   <= md_busy_d;
      ld_state_q  <= ld_state_d;
      ld_cnt_q    <= ld_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Pipeline controls: reset holds the front end with both stages flushed;
  // redirect beats stall.
  always_comb begin
    pc_write_en  = 1'b1;
    if_id_enable = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    if (rst) begin
      pc_write_en  = 1'b0;
      if_id_enable = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (stall) begin
      pc_write_en  = 1'b0;
      if_id_enable = 1'b0;
      id_ex_flush  = 1'b1;
    end
  end

  assign md_busy     = md_busy_q;
  assign sb_pending  = sb_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Parametrised successor of the pipeline hazard unit for the RV32IM 5-stage core. Adds a register scoreboard for the multi-cycle MUL/DIV unit, a configurable multi-cycle load-use stall, a structural stall on a busy MUL/DIV unit and a saturating stall-cycle performance counter. It sits beside the ID stage and drives PC, IF/ID and ID/EX stall and flush controls.

Parameters:
NUM_REGS, 32, architectural register count; scoreboard width
REG_AW, 5, register address width; must equal clog2(NUM_REGS)
LOAD_LAT, 1, load-use stall cycles (1..7); data-memory read latency minus forwarding
CNT_W, 16, stall_count width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
id_rs1_addr  in  REG_AW  rs1 of instruction in ID
id_rs2_addr  in  REG_AW  rs2 of instruction in ID
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
id_rd_addr  in  REG_AW  rd of instruction in ID
id_reg_write_en  in  1  ID instruction writes rd
id_is_md  in  1  ID instruction is MUL/DIV
ex_rd_addr  in  REG_AW  rd of instruction in EX
ex_mem_read_en  in  1  EX instruction is a load
ex_reg_write_en  in  1  EX instruction writes rd
ex_md_start  in  1  MUL/DIV issued from EX this cycle (rd = ex_rd_addr)
md_done  in  1  MUL/DIV writeback this cycle
md_rd_addr  in  REG_AW  rd of completing MUL/DIV
ex_redirect  in  1  jump/JALR/taken branch resolved in EX
pc_write_en  out  1  PC update enable
if_id_enable  out  1  IF/ID register enable
if_id_flush  out  1  IF/ID flush to NOP
id_ex_flush  out  1  ID/EX flush to NOP (bubble)
md_busy  out  1  MUL/DIV unit occupied
sb_pending  out  NUM_REGS  scoreboard pending-write bits
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (async, rst high): sb_pending=0, md_busy=0, load FSM=IDLE, stall_count=0. While rst high: pc_write_en=0, if_id_enable=0, if_id_flush=1, id_ex_flush=1.
- Scoreboard (registered): set bit ex_rd_addr on ex_md_start && ex_reg_write_en && ex_rd_addr!=0. Clear bit md_rd_addr on md_done. Set and clear of the same bit in one cycle -> set wins. Bit 0 always 0.
- md_busy: set on ex_md_start, cleared on md_done. Simultaneous done and start -> remains 1.
- sb_hazard (combinational, registered state only): (id_rs1_used && rs1!=0 && sb[rs1]) || (id_rs2_used && rs2!=0 && sb[rs2]) || (id_reg_write_en && id_rd_addr!=0 && sb[id_rd_addr]) (WAW). No bypass from md_done: stall persists through the done cycle and releases the next cycle.
- struct_hazard: id_is_md && md_busy.
- load_use: ex_mem_read_en && ex_reg_write_en && ex_rd_addr!=0 && ((id_rs1_used && ex_rd_addr==rs1) || (id_rs2_used && ex_rd_addr==rs2)).
- Load FSM: IDLE -> LD_STALL when load_use && !ex_redirect && LOAD_LAT>1, loading a down-counter with LOAD_LAT-1. In LD_STALL, stall is asserted every cycle and the counter decrements; return to IDLE when it reaches 1. Total stall = LOAD_LAT cycles. ex_redirect forces IDLE.
- stall = load_use || (state==LD_STALL) || sb_hazard || struct_hazard.
- Priority: redirect > stall > normal.
  - redirect: pc_write_en=1, if_id_enable=1, if_id_flush=1, id_ex_flush=1. Stall suppressed. A same-cycle ex_md_start is still accepted, because the MUL/DIV instruction is older.
  - stall: pc_write_en=0, if_id_enable=0, if_id_flush=0, id_ex_flush=1 (bubble into EX).
  - normal: 1,1,0,0.
- stall_count increments in every stall cycle (not redirect cycles) and saturates at all-ones.
- ex_md_start while md_busy && !md_done is a protocol violation; the structural stall guarantees it cannot occur.

Test Plan:
- Reset mid-operation: sb_pending=0x0000_0020, md_busy=1, assert rst -> sb_pending=0, md_busy=0, stall_count=0 immediately; outputs 0,0,1,1.
- RAW on MUL: ex_md_start rd=5, then ID reads rs1=5 -> stall (0,0,0,1) until md_done rd=5; released the cycle after done; sb_pending bit5 clears.
- LOAD_LAT=3, load rd=7 in EX, ID rs2=7 -> exactly 3 stall cycles, then normal; stall_count=3.
- Load-use coinciding with ex_redirect -> outputs 1,1,1,1; FSM IDLE; no following stall cycles.
- Structural: md_busy=1, id_is_md=1 with no register overlap -> stall; md_done and ex_md_start rd=9 in the same cycle -> md_busy stays 1, bit9 set.
- WAW and x0: sb[3]=1, ID writes rd=3 -> stall; ID reads rs1=0 -> no stall; ex_md_start rd=0 -> no bit set.
